// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package alu_mc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MULU = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles
// after start.  done is high during the last iteration cycle and product then
// shows the final low WIDTH bits, so the caller can latch both on that edge.
module alu_mc_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_nx;

  assign addend  = mplier[0] ? mcand : '0;
  assign acc_nx  = acc + addend;
  assign done    = running && (cnt == CW'(WIDTH - 1));
  assign product = acc_nx;

  // Load operands on start, then add one shifted multiplicand per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
    end else if (running) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative multiply.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready.  Once
// raised, out_valid and its result/zero/ovf hold until that transfer, and no
// new request is taken until the cycle after it.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  state_e           state;
  state_e           state_nx;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [SHW-1:0]   sh;

  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MULU);
  assign sh        = b[SHW-1:0];
  assign state_dbg = state;

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath; overflow only meaningful for ADD/SUB.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = a + b;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a - b;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> sh);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = is_mul ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        busy = 1'b1;
        if (mul_done) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Result registers: loaded on a single-cycle accept or multiplier finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept && !is_mul) begin
      result <= alu_res;
      zero   <= (alu_res == '0);
      ovf    <= alu_ovf;
    end else if ((state == ST_MUL) && mul_done) begin
      result <= mul_prod;
      zero   <= (mul_prod == '0);
      ovf    <= 1'b0;
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>=8, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present on a, b, op.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  4  operation code.
REQ-010 out_valid  output  1  result, zero, ovf are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  result == 0.
REQ-014 ovf  output  1  signed overflow flag.
REQ-015 busy  output  1  multiply in progress.

Function
REQ-016 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 1/0), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULU (low WIDTH bits of unsigned product); 12-15 SHALL yield result 0, ovf 0.
REQ-017 FSM SHALL have states IDLE, MUL, DONE; in_ready = (state == IDLE); busy = (state == MUL); out_valid = (state == DONE).
REQ-018 Accept occurs when in_valid && in_ready; a, b, op SHALL be captured on accept and never resampled.
REQ-019 IDLE + accept of a non-MULU op -> DONE next cycle with result registered (latency 1).
REQ-020 IDLE + accept of MULU -> MUL; shift-add multiplier SHALL run exactly WIDTH cycles, then -> DONE (out_valid WIDTH+1 cycles after accept).
REQ-021 DONE SHALL hold result, zero, ovf stable until out_ready; DONE && out_ready -> IDLE next cycle.
REQ-022 No request SHALL be accepted in MUL or DONE, including the cycle out_ready is high (max throughput one result per 2 cycles).
REQ-023 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf = signed overflow for ADD/SUB only, 0 for all other ops.
REQ-024 Shifts SHALL use b[SHW-1:0] only; shift of 0 returns a unchanged.
REQ-025 zero SHALL be computed from the registered result, including MULU.

Reset
REQ-026 rst SHALL force IDLE, result 0, zero 0, ovf 0, multiplier counter/accumulator 0, dominating all other inputs in that cycle.
REQ-027 rst asserted during MUL or DONE SHALL abort the operation with no out_valid; in_ready SHALL be 1 the cycle after rst deasserts.

Structure
REQ-028 Package alu_mc_pkg SHALL hold the opcode enum/constants and the FSM state typedef.
REQ-029 Multiplier SHALL be sub-module alu_mc_mul (start, a, b -> done, product low WIDTH bits, WIDTH-cycle iterative).

Verification
REQ-030 ADD a=0x7FFFFFFF b=1 -> out_valid cycle after accept, result 0x80000000, ovf 1, zero 0.
REQ-031 SUB a=5 b=5 -> result 0, zero 1, ovf 0; SLT a=0xFFFFFFFF b=1 -> 1, SLTU same operands -> 0.
REQ-032 MULU a=0x0001_0003 b=0x0000_0010 -> busy 32 cycles, out_valid 33 cycles after accept, result 0x0010_0030.
REQ-033 SRA a=0x80000000 b=0x21 -> result 0xC0000000 (shift 1); op=14 -> result 0.
REQ-034 out_ready held low 10 cycles in DONE -> outputs stable, in_ready 0, in_valid ignored; out_ready high -> in_ready 1 next cycle.
REQ-035 rst pulsed 5 cycles into MULU -> no out_valid, all outputs 0, next ADD 2+3 -> 5 with latency 1.
